// File: rtl/depuncturer.sv
// 802.11a RX depuncturer: rebuilds rate-1/2 (A,B) pairs with erasure flags.
// Optional output-pair counter port oPairCnt is enabled by `define DEPUNC_PAIR_CNT_EN.
module depuncturer #(
    parameter int CNT_W = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEN,
    input  logic             iRateEN,
    input  logic [3:0]       iRate,
    input  logic             iValid,
    input  logic             iData,
    output logic             oA,
    output logic             oB,
    output logic             oEraA,
    output logic             oEraB,
    output logic             oValid,
    output logic             oRateErr
`ifdef DEPUNC_PAIR_CNT_EN
    ,
    output logic [CNT_W-1:0] oPairCnt
`endif
);

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_R12  = 2'd1,
        MODE_R23  = 2'd2,
        MODE_R34  = 2'd3
    } mode_t;

    mode_t      r_mode;
    logic [1:0] r_phase;
    logic       r_hold;
    logic       r_a;
    logic       r_b;
    logic       r_eraA;
    logic       r_eraB;
    logic       r_valid;
    logic       r_rateErr;

    mode_t      w_newMode;
    logic       w_newErr;
    logic [1:0] w_lastPhase;
    logic       w_accept;
    logic       w_emit;

    always_comb begin
        w_newMode = MODE_NONE;
        w_newErr  = 1'b0;
        unique case (iRate)
            4'b1101, 4'b0101, 4'b1001:          w_newMode = MODE_R12;
            4'b0001:                            w_newMode = MODE_R23;
            4'b1111, 4'b0111, 4'b1011, 4'b0011: w_newMode = MODE_R34;
            default: begin
                w_newMode = MODE_NONE;
                w_newErr  = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_lastPhase = 2'd0;
        unique case (r_mode)
            MODE_R12: w_lastPhase = 2'd1;
            MODE_R23: w_lastPhase = 2'd2;
            MODE_R34: w_lastPhase = 2'd3;
            default:  w_lastPhase = 2'd0;
        endcase
    end

    // A rate strobe takes precedence over any bit presented in the same cycle.
    assign w_accept = iEN & iValid & ~iRateEN & (r_mode != MODE_NONE);
    assign w_emit   = w_accept & (r_phase != 2'd0);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_mode    <= MODE_NONE;
            r_phase   <= 2'd0;
            r_hold    <= 1'b0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_eraA    <= 1'b0;
            r_eraB    <= 1'b0;
            r_valid   <= 1'b0;
            r_rateErr <= 1'b0;
        end else begin
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_eraA  <= 1'b0;
            r_eraB  <= 1'b0;
            r_valid <= 1'b0;
            if (iRateEN) begin
                r_mode    <= w_newMode;
                r_rateErr <= w_newErr;
                r_phase   <= 2'd0;
                r_hold    <= 1'b0;
            end else if (w_accept) begin
                r_phase <= (r_phase == w_lastPhase) ? 2'd0 : r_phase + 2'd1;
                // Phase 2 carries a stolen B, phase 3 a stolen A.
                unique case (r_phase)
                    2'd0: r_hold <= iData;
                    2'd1: begin
                        r_valid <= 1'b1;
                        r_a     <= r_hold;
                        r_b     <= iData;
                    end
                    2'd2: begin
                        r_valid <= 1'b1;
                        r_a     <= iData;
                        r_eraB  <= 1'b1;
                    end
                    default: begin
                        r_valid <= 1'b1;
                        r_b     <= iData;
                        r_eraA  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign oA       = r_a;
    assign oB       = r_b;
    assign oEraA    = r_eraA;
    assign oEraB    = r_eraB;
    assign oValid   = r_valid;
    assign oRateErr = r_rateErr;

`ifdef DEPUNC_PAIR_CNT_EN
    logic [CNT_W-1:0] r_pairCnt;

    always_ff @(posedge iClk) begin
        if (iRst || iRateEN) begin
            r_pairCnt <= '0;
        end else if (w_emit) begin
            r_pairCnt <= r_pairCnt + 1'b1;
        end
    end

    assign oPairCnt = r_pairCnt;
`endif

endmodule
